// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit register file with two combinational read ports,
// write-first bypass, hardwired-zero r0 and a post-reset sequential clear.
module reg_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy,
  output logic              wr_err
);

  localparam int unsigned       Depth   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] FirstIdx = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LastIdx  = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_idx_q;
  logic              busy_q;
  logic              wr_err_q;

  // Clear sequencer; busy and wr_err are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StClear;
      clr_idx_q <= FirstIdx;
      busy_q    <= 1'b1;
      wr_err_q  <= 1'b0;
    end else begin
      // A write presented while clearing is dropped and flagged for one cycle.
      wr_err_q <= we & busy_q;
      unique case (state_q)
        StClear: begin
          if (clr_idx_q == LastIdx) begin
            state_q <= StReady;
            busy_q  <= 1'b0;
          end else begin
            clr_idx_q <= clr_idx_q + FirstIdx;
          end
        end
        StReady: begin
          state_q <= StReady;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Single write path shared by the clear sequence and user writes.
  logic              clr_wr;
  logic              usr_wr;
  logic              wr_any;
  logic [ADDR_W-1:0] wr_idx;
  logic [DATA_W-1:0] wr_data;

  // Write-port decode: clear has priority and only runs in StClear.
  always_comb begin
    clr_wr  = ~rst & (state_q == StClear);
    usr_wr  = ~rst & (state_q == StReady) & we & (wa != '0);
    wr_any  = clr_wr | usr_wr;
    wr_idx  = clr_wr ? clr_idx_q : wa;
    wr_data = clr_wr ? '0 : wd;
  end

  // Read view of all registers; entry 0 is a constant, r0 has no storage.
  logic [DATA_W-1:0] rd_arr [Depth];

  assign rd_arr[0] = '0;

  for (genvar i = 1; i < Depth; i++) begin : g_reg
    logic [DATA_W-1:0] q;

    // Storage for register i; no reset, the clear sequence zeroes it.
    always_ff @(posedge clk) begin
      if (wr_any && (wr_idx == ADDR_W'(i))) begin
        q <= wr_data;
      end
    end

    assign rd_arr[i] = q;
  end

  // Read port 1: busy and r0 force zero, then write-first bypass, then storage.
  always_comb begin
    rd1 = rd_arr[ra1];
    if (busy_q || (ra1 == '0)) begin
      rd1 = '0;
    end else if (we && (wa == ra1)) begin
      rd1 = wd;
    end
  end

  // Read port 2: same priority as port 1, evaluated independently.
  always_comb begin
    rd2 = rd_arr[ra2];
    if (busy_q || (ra2 == '0)) begin
      rd2 = '0;
    end else if (we && (wa == ra2)) begin
      rd2 = wd;
    end
  end

  assign busy   = busy_q;
  assign wr_err = wr_err_q;

endmodule
